mnist_frame_binarizer: RTL and testbench
========================================

Name: mnist_frame_binarizer

Overview:
- Upstream feeder for the combinational LLNN `top`. Its output drives `NET_I` directly.
- Accepts a raster-order stream of 28x28 8-bit grayscale MNIST pixels over a valid/ready interface.
- Crops the centred 20x20 window and thresholds each pixel to 1 bit.
- Assembles the bits into a NET_INPUTS-wide (400-bit) frame and presents it on a valid/ready output. Double-buffered, so the next frame can be assembled while the current one is held.

Parameters:
- IMG_W, 28, input image width in pixels
- IMG_H, 28, input image height in pixels
- CROP_OFF, 4, first cropped row and column index
- CROP_W, 20, crop window side; CROP_W*CROP_W must equal NET_INPUTS
- PIX_W, 8, pixel width in bits
- THRESH, 128, binarization threshold; a pixel maps to 1 when pixel >= THRESH (unsigned compare)

Ports:
- clk  in  1  system clock (the single clock), rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel beat valid
- in_ready  out  1  block accepts a beat
- in_pixel  in  PIX_W  grayscale pixel, raster order (row-major, row 0 col 0 first)
- in_last  in  1  marks the final pixel of a frame
- out_valid  out  1  out_frame holds a complete frame
- out_ready  in  1  consumer accepts the frame
- out_frame  out  NET_INPUTS  binarized frame, connects to NET_I
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset and clocking: one clock domain. Reset is asynchronous and active-low. On reset: row=0, col=0, assembly register=0, out_frame=0, out_valid=0, frame_err=0, state=FILL, in_ready=1.
- Beat counting: a beat is accepted when in_valid&&in_ready. col counts 0..IMG_W-1 and wraps, incrementing row. row counts 0..IMG_H-1.
- Cropping and bit placement:
  - Only beats with row and col both in [CROP_OFF, CROP_OFF+CROP_W-1] are kept.
  - A kept pixel maps to bit index k = (row-CROP_OFF)*CROP_W + (col-CROP_OFF).
  - Crop pixel (0,0) therefore lands in bit 0 (LSB) and (19,19) in bit 399.
  - Bits outside the crop window are dropped.
- Binarization: bit = (in_pixel >= THRESH).
- Frame completion: occurs on the accepted beat at row=IMG_H-1, col=IMG_W-1 with in_last=1 (call it cycle N).
  - If the output buffer is free at N, or out_ready&&out_valid at N: copy the assembly register into out_frame, out_valid=1 at N+1, counters=0, assembly register cleared.
  - Otherwise state goes to HOLD.
- States:
  - FILL: in_ready=1.
  - HOLD: in_ready=0. On the cycle where out_valid&&out_ready, transfer the held frame. out_valid stays 1 with the new data. Return to FILL next cycle.
- Output handshake:
  - out_valid deasserts after out_valid&&out_ready unless a transfer happens in the same cycle.
  - out_frame is stable while out_valid=1 and not accepted.
- Framing errors: both cases pulse frame_err for one cycle (N+1), discard the assembly, reset counters to 0, and leave out_valid/out_frame untouched. The next beat is row 0, col 0.
  - in_last=1 on any beat before the final position.
  - The final position is reached with in_last=0.
- in_valid low mid-frame: counters hold; no timeout.
- Reset mid-frame or mid-HOLD: all state is lost, and the partial or pending frame is dropped.

Optional Feature:
- Macro: FRAME_ERR_CNT_EN.
- Defined: adds output port err_cnt [7:0], a saturating count (stops at 255) of frame_err pulses. Reset to 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package: NET_INPUTS, IMG_W/IMG_H/CROP_OFF/CROP_W defaults, PIX_W, and the state enum {FILL, HOLD}.
- One natural sub-module: mnist_crop_counter. It owns the row/col counters and produces the in_crop flag, bit index k, the is_final flag and the early-last detection.

Test Plan:
- All 784 pixels = 255, out_ready=1 -> one out_valid pulse; out_frame = all ones (400 bits); frame_err never pulses.
- All pixels = 127 except crop (0,0) (row 4, col 4) = 128 -> out_frame = 400'h1. Same test with crop (19,19) = 255 -> only bit 399 set.
- Border pixels (any row or col outside 4..23) = 255, crop pixels = 0 -> out_frame = 0, out_valid=1.
- Backpressure:
  - Setup: out_ready=0; send frame A (all ones), then frame B (all zeros).
  - Expect: in_ready drops to 0 after B's final beat, out_frame stays A.
  - Raise out_ready for 1 cycle: A accepted, next cycle out_frame=0 with out_valid=1, in_ready=1.
- Early last: in_last=1 on beat 100 -> frame_err pulses once, no out_valid; the following clean 784-beat frame is produced correctly. With FRAME_ERR_CNT_EN defined, err_cnt=1.
- Reset mid-frame: assert rst_n=0 after beat 400 -> out_valid=0 and out_frame=0 immediately; a full frame sent after release is produced correctly.

Source files
------------

// File: rtl/mnist_frame_binarizer_pkg.sv
// Shared constants and types for the MNIST frame binarizer.
// Geometry defaults: 28x28 8-bit input, centred 20x20 crop, threshold 128.
package mnist_frame_binarizer_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int CROP_OFF   = 4;
    localparam int CROP_W     = 20;
    localparam int PIX_W      = 8;
    localparam int THRESH     = 128;
    localparam int NET_INPUTS = CROP_W * CROP_W;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int K_W   = $clog2(NET_INPUTS);

    // Sized comparison constants so counter compares stay width-clean.
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_CROP_LO = COL_W'(CROP_OFF);
    localparam logic [COL_W-1:0] COL_CROP_HI = COL_W'(CROP_OFF + CROP_W - 1);
    localparam logic [ROW_W-1:0] ROW_CROP_LO = ROW_W'(CROP_OFF);
    localparam logic [ROW_W-1:0] ROW_CROP_HI = ROW_W'(CROP_OFF + CROP_W - 1);
    localparam logic [PIX_W-1:0] THRESH_V    = PIX_W'(THRESH);

    // FILL: accepting pixels; HOLD: a finished frame waits for the output buffer.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mnist_crop_counter.sv
// Raster position tracker: row/col counters, crop-window flag, bit index,
// final-position flag and early-last detection for the frame binarizer.
module mnist_crop_counter
    import mnist_frame_binarizer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           beat,
    input  logic           in_last,
    output logic           in_crop,
    output logic [K_W-1:0] k_idx,
    output logic           is_final,
    output logic           early_last
);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_rel;
    logic [COL_W-1:0] col_rel;

    // Decode the current position into crop membership and destination bit.
    always_comb begin
        in_crop    = (row_q >= ROW_CROP_LO) && (row_q <= ROW_CROP_HI) &&
                     (col_q >= COL_CROP_LO) && (col_q <= COL_CROP_HI);
        row_rel    = row_q - ROW_CROP_LO;
        col_rel    = col_q - COL_CROP_LO;
        k_idx      = K_W'(row_rel) * K_W'(CROP_W) + K_W'(col_rel);
        is_final   = (row_q == ROW_LAST) && (col_q == COL_LAST);
        early_last = in_last && !is_final;
    end

    // Advance on each accepted beat; any frame end (good or bad) restarts at 0,0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (beat) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (is_final || in_last) begin
                row_q <= '0;
                col_q <= '0;
            end else if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/mnist_frame_binarizer.sv
// Streams 28x28 grayscale pixels in, crops the centred 20x20 window,
// thresholds each pixel and presents a double-buffered 400-bit frame.
// Optional build macro FRAME_ERR_CNT_EN adds a saturating err_cnt output.
module mnist_frame_binarizer
    import mnist_frame_binarizer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_W-1:0]      in_pixel,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NET_INPUTS-1:0] out_frame,
    output logic                  frame_err
`ifdef FRAME_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    state_t                state_q;
    logic [NET_INPUTS-1:0] asm_q;
    logic [NET_INPUTS-1:0] asm_next;
    logic                  beat;
    logic                  pix_bit;
    logic                  in_crop;
    logic [K_W-1:0]        k_idx;
    logic                  is_final;
    logic                  early_last;
    logic                  frame_done;
    logic                  frame_bad;
    logic                  out_free;
    logic                  out_take;

    assign in_ready = (state_q == FILL);

    mnist_crop_counter u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat       (beat),
        .in_last    (in_last),
        .in_crop    (in_crop),
        .k_idx      (k_idx),
        .is_final   (is_final),
        .early_last (early_last)
    );

    // Handshake qualifiers and the assembly image including the current beat.
    always_comb begin
        // NOTE: default every always_comb output first so no latch is inferred.
        asm_next   = asm_q;
        beat       = in_valid && in_ready;
        pix_bit    = (in_pixel >= THRESH_V);
        frame_done = beat && is_final && in_last;
        frame_bad  = beat && (early_last || (is_final && !in_last));
        out_free   = !out_valid || out_ready;
        out_take   = out_valid && out_ready;
        if (in_crop) begin
            asm_next[k_idx] = pix_bit;
        end
    end

    // Frame FSM: assemble, hand off to the output buffer, or hold when it is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both frame buffers are plain flops and must clear on reset.
            state_q   <= FILL;
            asm_q     <= '0;
            out_frame <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_q)
                FILL: begin
                    if (out_take) begin
                        out_valid <= 1'b0;
                    end
                    if (frame_done) begin
                        if (out_free) begin
                            out_frame <= asm_next;
                            out_valid <= 1'b1;
                            asm_q     <= '0;
                        end else begin
                            asm_q   <= asm_next;
                            state_q <= HOLD;
                        end
                    end else if (frame_bad) begin
                        frame_err <= 1'b1;
                        asm_q     <= '0;
                    end else if (beat) begin
                        asm_q <= asm_next;
                    end
                end
                HOLD: begin
                    // out_valid is necessarily high here and stays high with new data.
                    if (out_take) begin
                        out_frame <= asm_q;
                        asm_q     <= '0;
                        state_q   <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef FRAME_ERR_CNT_EN
    // Saturating tally of framing-error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mnist_frame_binarizer.sv
// Self-checking bench for mnist_frame_binarizer: directed cases plus
// randomized frames against a queue-based frame model.
module tb_mnist_frame_binarizer;

    localparam int W      = 28;
    localparam int NPIX   = W * W;
    localparam int OFF    = 4;
    localparam int CW     = 20;
    localparam int NB     = CW * CW;
    localparam int BEAT_TIMEOUT  = 2000;
    localparam int DRAIN_TIMEOUT = 4000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] out_frame;
    logic          frame_err;
`ifdef FRAME_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    mnist_frame_binarizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame),
        .frame_err (frame_err)
`ifdef FRAME_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_bad   = 0;
    int            err_obs = 0;
    int            hs_obs  = 0;
    int            err_exp = 0;
    bit            rand_ready_en = 1'b0;
    bit            gaps_en = 1'b0;
    logic [7:0]    img [NPIX];
    logic [NB-1:0] exp_q [$];

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected frame straight from the crop/threshold rules.
    function automatic logic [NB-1:0] model_frame();
        logic [NB-1:0] f = '0;
        for (int r = 0; r < CW; r++)
            for (int c = 0; c < CW; c++)
                f[r*CW + c] = (img[(r+OFF)*W + (c+OFF)] >= 8'd128);
        return f;
    endfunction

    // Compare process: whenever out_valid is high the frame must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_obs++;
            if (out_valid) begin
                check("valid_has_expect", NB'(exp_q.size() != 0), NB'(1));
                if (exp_q.size() != 0) begin
                    check("out_frame", out_frame, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_obs++;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_beat(input logic [7:0] p, input logic l);
        int   waitc = 0;
        logic rdy;
        if (gaps_en) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = p;
        in_last  = l;
        forever begin
            if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waitc++;
            if (waitc > BEAT_TIMEOUT) begin
                $display("FAIL beat_timeout: in_ready stuck low for %0d cycles", waitc);
                $fatal(1, "beat timeout");
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send beats 0..n_beats-1 of img; in_last on index last_at (-1: never).
    task automatic send_frame(input int n_beats, input int last_at);
        logic [NB-1:0] f;
        f = model_frame();
        for (int i = 0; i < n_beats; i++)
            send_beat(img[i], 1'(i == last_at));
        if (n_beats == NPIX && last_at == NPIX - 1) exp_q.push_back(f);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < DRAIN_TIMEOUT) begin
            if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, NB'(n < DRAIN_TIMEOUT), NB'(1));
    endtask

    task automatic fill_all(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    initial begin
        logic [NB-1:0] all1;
        logic [NB-1:0] bit0;
        logic [NB-1:0] bit399;
        int            hs0;
        int            err0;
        all1   = '1;
        bit0   = NB'(1);
        bit399 = NB'(1) << 399;

        rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", NB'(out_valid), NB'(0));
        check("rst_out_frame", out_frame, '0);
        check("rst_frame_err", NB'(frame_err), NB'(0));
        check("rst_in_ready", NB'(in_ready), NB'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All white frame.
        out_ready = 1'b1;
        fill_all(8'd255);
        check("model_all_ones", model_frame(), all1);
        hs0 = hs_obs;
        send_frame(NPIX, NPIX - 1);
        drain("all_ones");
        check("all_ones_one_pulse", NB'(hs_obs - hs0), NB'(1));
        check("all_ones_no_err", NB'(err_obs), NB'(0));

        // Threshold edge at crop (0,0), then 255 at crop (19,19).
        fill_all(8'd127);
        img[OFF*W + OFF] = 8'd128;
        check("model_bit0", model_frame(), bit0);
        send_frame(NPIX, NPIX - 1);
        drain("bit0");
        fill_all(8'd127);
        img[(OFF+CW-1)*W + (OFF+CW-1)] = 8'd255;
        check("model_bit399", model_frame(), bit399);
        send_frame(NPIX, NPIX - 1);
        drain("bit399");

        // White border, black crop: all-zero frame must still be delivered.
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                img[r*W + c] = (r >= OFF && r < OFF+CW && c >= OFF && c < OFF+CW) ? 8'd0 : 8'd255;
        check("model_border", model_frame(), '0);
        hs0 = hs_obs;
        send_frame(NPIX, NPIX - 1);
        drain("border");
        check("border_one_pulse", NB'(hs_obs - hs0), NB'(1));

        // Backpressure: A held on the output, B held in the assembly buffer.
        out_ready = 1'b0;
        fill_all(8'd255);
        send_frame(NPIX, NPIX - 1);
        fill_all(8'd0);
        send_frame(NPIX, NPIX - 1);
        check("bp_in_ready_low", NB'(in_ready), NB'(0));
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_low", NB'(in_ready), NB'(0));
        check("bp_hold_a", out_frame, all1);
        check("bp_valid_a", NB'(out_valid), NB'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_frame_b", out_frame, '0);
        check("bp_valid_b", NB'(out_valid), NB'(1));
        check("bp_in_ready_back", NB'(in_ready), NB'(1));
        out_ready = 1'b1;
        drain("bp");

        // Early last on beat 100, then a clean frame.
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        hs0 = hs_obs; err0 = err_obs;
        send_frame(101, 100);
        err_exp++;
        repeat (4) @(posedge clk);
        #1;
        check("early_err_pulse", NB'(err_obs - err0), NB'(1));
        check("early_no_valid", NB'(hs_obs - hs0), NB'(0));
`ifdef FRAME_ERR_CNT_EN
        check("early_err_cnt", NB'(err_cnt), NB'(1));
`endif
        send_frame(NPIX, NPIX - 1);
        drain("after_early");

        // Final position reached without in_last.
        err0 = err_obs;
        send_frame(NPIX, -1);
        err_exp++;
        repeat (4) @(posedge clk);
        #1;
        check("missing_last_err", NB'(err_obs - err0), NB'(1));
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        send_frame(NPIX, NPIX - 1);
        drain("after_missing");

        // Reset in the middle of a frame.
        send_frame(401, -1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", NB'(out_valid), NB'(0));
        check("midrst_frame", out_frame, '0);
        check("midrst_in_ready", NB'(in_ready), NB'(1));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        send_frame(NPIX, NPIX - 1);
        drain("after_rst");
`ifdef FRAME_ERR_CNT_EN
        check("rst_err_cnt", NB'(err_cnt), NB'(0));
`endif

        // Randomized traffic with idle gaps and random output backpressure.
        rand_ready_en = 1'b1;
        gaps_en       = 1'b1;
        err0 = err_obs;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPIX; i++)
                img[i] = (f % 2 == 0) ? 8'($urandom) : 8'($urandom_range(120, 135));
            send_frame(NPIX, NPIX - 1);
        end
        drain("random");
        check("random_no_err", NB'(err_obs - err0), NB'(0));
        check("total_err_pulses", NB'(err_obs), NB'(err_exp));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
